// File: rtl/dpram_sclk_be.sv
// dpram_sclk_be: single-clock true dual-port RAM with byte-lane writes and a write-write collision monitor.
// Optional macro DPRAM_SCLK_BE_OUT_REG_EN adds one output register stage per port (read latency 2).
module dpram_sclk_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int BYTE_W   = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_a,
  input  logic                       en_b,
  input  logic                       we_a,
  input  logic                       we_b,
  input  logic [DATA_W/BYTE_W-1:0]   be_a,
  input  logic [DATA_W/BYTE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0]          addr_a,
  input  logic [ADDR_W-1:0]          addr_b,
  input  logic [DATA_W-1:0]          data_a,
  input  logic [DATA_W-1:0]          data_b,
  output logic [DATA_W-1:0]          q_a,
  output logic [DATA_W-1:0]          q_b,
  output logic                       valid_a,
  output logic                       valid_b,
  output logic                       coll,
  output logic [15:0]                coll_cnt
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_a, wr_b, same_addr;
  logic [NB-1:0]     lane_a, lane_b;
  logic [DATA_W-1:0] old_a, old_b, fin_a, fin_b, rd_a, rd_b;

  logic [DATA_W-1:0] q1_a_d, q1_a_q, q1_b_d, q1_b_q;
  logic              vld1_a_d, vld1_a_q, vld1_b_d, vld1_b_q;
  logic              coll_d, coll_q;
  logic [15:0]       coll_cnt_d, coll_cnt_q;

  // Effective lane writes: B loses every lane A also writes at the same address.
  always_comb begin
    wr_a      = en_a & we_a & (|be_a);
    wr_b      = en_b & we_b & (|be_b);
    same_addr = (addr_a == addr_b);
    lane_a    = wr_a ? be_a : '0;
    lane_b    = wr_b ? (be_b & ~((wr_a && same_addr) ? be_a : '0)) : '0;
  end

  // Final stored word at each port's address, used by write-first returns.
  always_comb begin
    old_a = mem[addr_a];
    old_b = mem[addr_b];
    fin_a = old_a;
    fin_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (lane_a[i])
        fin_a[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
      if (lane_b[i] && same_addr)
        fin_a[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
      if (lane_b[i])
        fin_b[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
      if (lane_a[i] && same_addr)
        fin_b[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
    end
    rd_a = (RDW_MODE == 0 && wr_a) ? fin_a : old_a;
    rd_b = (RDW_MODE == 0 && wr_b) ? fin_b : old_b;
  end

  // Storage is never reset, and a write seen while rst_n is low is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_a[i])
          mem[addr_a][i*BYTE_W +: BYTE_W] <= data_a[i*BYTE_W +: BYTE_W];
        if (lane_b[i])
          mem[addr_b][i*BYTE_W +: BYTE_W] <= data_b[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    q1_a_d     = en_a ? rd_a : q1_a_q;
    q1_b_d     = en_b ? rd_b : q1_b_q;
    vld1_a_d   = en_a;
    vld1_b_d   = en_b;
    coll_d     = wr_a & wr_b & same_addr & (|(be_a & be_b));
    coll_cnt_d = coll_cnt_q;
    if (coll_d && coll_cnt_q != 16'hFFFF)
      coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_a_q     <= '0;
      q1_b_q     <= '0;
      vld1_a_q   <= 1'b0;
      vld1_b_q   <= 1'b0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      q1_a_q     <= q1_a_d;
      q1_b_q     <= q1_b_d;
      vld1_a_q   <= vld1_a_d;
      vld1_b_q   <= vld1_b_d;
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

`ifdef DPRAM_SCLK_BE_OUT_REG_EN
  logic [DATA_W-1:0] q2_a_d, q2_a_q, q2_b_d, q2_b_q;
  logic              vld2_a_d, vld2_a_q, vld2_b_d, vld2_b_q;

  // Second stage only advances behind a valid first stage, so q holds between accesses.
  always_comb begin
    q2_a_d   = vld1_a_q ? q1_a_q : q2_a_q;
    q2_b_d   = vld1_b_q ? q1_b_q : q2_b_q;
    vld2_a_d = vld1_a_q;
    vld2_b_d = vld1_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_a_q   <= '0;
      q2_b_q   <= '0;
      vld2_a_q <= 1'b0;
      vld2_b_q <= 1'b0;
    end else begin
      q2_a_q   <= q2_a_d;
      q2_b_q   <= q2_b_d;
      vld2_a_q <= vld2_a_d;
      vld2_b_q <= vld2_b_d;
    end
  end

  assign q_a     = q2_a_q;
  assign q_b     = q2_b_q;
  assign valid_a = vld2_a_q;
  assign valid_b = vld2_b_q;
`else
  assign q_a     = q1_a_q;
  assign q_b     = q1_b_q;
  assign valid_a = vld1_a_q;
  assign valid_b = vld1_b_q;
`endif

  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;

endmodule
